match_burst_fsm: RTL and testbench
==================================

MATCH_BURST_FSM -- requirements
Module: match_burst_fsm

Interface
REQ-001 Parameter SYM_W, default 4, width of the num, seq and mask symbols.
REQ-002 Parameter CNT_W, default 4, width of the match counter.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 valid  input  1  high while a sequence window is open.
REQ-006 num  input  SYM_W  target symbol.
REQ-007 seq  input  SYM_W  observed symbol, sampled while valid=1.
REQ-008 mask  input  SYM_W  compare enable per bit; 1 = bit is compared.
REQ-009 state  output  STATE  current FSM state.
REQ-010 cnt  output  CNT_W  current match count / remaining hits.
REQ-011 hit  output  1  high exactly while state=ASSERT.
REQ-012 drop  output  1  one-cycle flag: valid ignored because state=ASSERT.
REQ-013 ovf  output  1  sticky flag: a match was lost to saturation in the current window.
REQ-014 busy  output  1  high while state is not WAIT.

Function
REQ-015 Match SHALL be ((seq XOR num) AND mask) == 0; mask=0 makes every valid cycle a match.
REQ-016 States SHALL be WAIT, WATCH and ASSERT; any other encoding SHALL go to WAIT on the next edge.
REQ-017 WAIT, valid=1 -> WATCH; cnt loads 1 on a match, else 0; ovf clears to 0.
REQ-018 WAIT, valid=0 -> stay in WAIT; cnt and ovf hold.
REQ-019 WATCH, valid=1 -> stay in WATCH; cnt increments on a match.
REQ-020 WATCH, valid=0, cnt=0 -> WAIT.
REQ-021 WATCH, valid=0, cnt>0 -> ASSERT; cnt holds.
REQ-022 ASSERT: cnt decrements each cycle; cnt>1 stays in ASSERT; cnt=1 goes to WAIT with cnt becoming 0.
REQ-023 hit SHALL be high for exactly N consecutive cycles, N = count at WATCH exit, starting the cycle after valid falls.
REQ-024 Increment SHALL saturate at 2^CNT_W-1; a match at saturation holds cnt and sets ovf.
REQ-025 ovf SHALL hold through ASSERT and WAIT until the next WAIT->WATCH transition.
REQ-026 drop = valid AND (state=ASSERT), combinational; valid and seq are otherwise ignored in ASSERT.
REQ-027 valid held high on the cycle ASSERT exits to WAIT SHALL be ignored for that cycle: drop=1.
REQ-028 The next cycle is in WAIT, so a still-high valid SHALL start a new window then.
REQ-029 hit, busy and drop SHALL be combinational from registered state and inputs; cnt, state and ovf SHALL be registered.
REQ-030 No bit widths are implicit: increment and decrement SHALL be CNT_W-bit.
REQ-031 cnt SHALL never wrap.

Reset
REQ-032 reset_n=0 at a rising edge SHALL force state=WAIT, cnt=0, ovf=0.
REQ-033 Reset SHALL override all other inputs.
REQ-034 During and after reset, hit=0, busy=0 and drop=0.
REQ-035 Reset asserted mid-WATCH or mid-ASSERT SHALL abort the window with no further hit cycles.

Structure
REQ-036 The STATE enum (WAIT, WATCH, ASSERT) SHALL live in the shared FSM package.
REQ-037 The default SYM_W/CNT_W constants SHALL live in the same shared FSM package.
REQ-038 One sub-module, match_sat_cnt, SHALL implement the saturating up/down/load counter and the ovf detection.
REQ-039 match_burst_fsm SHALL contain the next-state logic, the match compare and the output decode.

Verification
REQ-040 Defaults, mask=F, num=5, valid high 4 cycles with seq=5,3,5,5 -> cnt=3, then hit high exactly 3 cycles, then WAIT with cnt=0.
REQ-041 valid high 2 cycles, seq never equal to num -> WATCH then WAIT, hit never asserted, cnt=0.
REQ-042 mask=0, valid high 20 cycles -> cnt saturates at 15, ovf=1, hit high 15 cycles.
REQ-043 Scenario REQ-042 continued: ovf stays 1 until the next window starts, then clears.
REQ-044 mask=C, num=4, seq=7 for 3 cycles -> 3 matches, hit high 3 cycles.
REQ-045 valid raised on the 2nd ASSERT cycle and held -> drop=1 while in ASSERT, hit count unchanged; valid still high after return to WAIT starts a new WATCH.
REQ-046 reset_n=0 on the 2nd hit cycle -> next cycle state=WAIT, cnt=0, hit=0, ovf=0.

Source files
------------

// File: rtl/match_burst_fsm_pkg.sv
// Shared definitions for the match/burst FSM: state encoding and default widths.
package match_burst_fsm_pkg;

   localparam int unsigned SYM_W_DEF = 4;
   localparam int unsigned CNT_W_DEF = 4;

   typedef enum logic [1:0] {
      WAIT   = 2'b00,
      WATCH  = 2'b01,
      ASSERT = 2'b10
   } state_t;

endpackage

// File: rtl/match_sat_cnt.sv
// Saturating match counter: load 0/1 at window start, count matches up to
// all-ones (flagging lost matches in a sticky ovf), count down during the burst.
module match_sat_cnt #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic             load_one,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   // Counter and overflow register; load has priority and restarts ovf.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (load) begin
         cnt <= load_one ? CNT_W'(1) : '0;
         ovf <= 1'b0;
      end else if (inc) begin
         if (cnt == '1) begin
            ovf <= 1'b1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/match_burst_fsm.sv
// Counts masked symbol matches while valid is high, then asserts hit for as
// many cycles as matches were counted. Valid is ignored (drop) during the burst.
module match_burst_fsm
   import match_burst_fsm_pkg::*;
#(
   parameter int unsigned SYM_W = SYM_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             valid,
   input  logic [SYM_W-1:0] num,
   input  logic [SYM_W-1:0] seq,
   input  logic [SYM_W-1:0] mask,
   output state_t           state,
   output logic [CNT_W-1:0] cnt,
   output logic             hit,
   output logic             drop,
   output logic             ovf,
   output logic             busy
);

   state_t state_next;
   logic   match;
   logic   cnt_load;
   logic   cnt_inc;
   logic   cnt_dec;

   assign match = (((seq ^ num) & mask) == '0);

   match_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_one (match),
      .inc      (cnt_inc),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .ovf      (ovf)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= WAIT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, counter control and output decode.
   always_comb begin
      state_next = WAIT;
      cnt_load   = 1'b0;
      cnt_inc    = 1'b0;
      cnt_dec    = 1'b0;
      hit        = 1'b0;
      drop       = 1'b0;
      busy       = 1'b1;
      case (state)
         WAIT: begin
            busy = 1'b0;
            if (valid) begin
               state_next = WATCH;
               cnt_load   = 1'b1;
            end
         end
         WATCH: begin
            if (valid) begin
               state_next = WATCH;
               cnt_inc    = match;
            end else if (cnt == '0) begin
               state_next = WAIT;
            end else begin
               state_next = ASSERT;
            end
         end
         ASSERT: begin
            hit        = 1'b1;
            drop       = valid;
            cnt_dec    = 1'b1;
            state_next = (cnt > CNT_W'(1)) ? ASSERT : WAIT;
         end
         default: begin
            state_next = WAIT;
         end
      endcase
   end

endmodule

// File: tb/tb_match_burst_fsm.sv
// Self-checking bench for match_burst_fsm: directed scenarios plus a randomized
// run against a window/burst reference model.
module tb_match_burst_fsm;
   import match_burst_fsm_pkg::*;

   localparam int MAXC = 15;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       valid;
   logic [3:0] num;
   logic [3:0] seq;
   logic [3:0] mask;
   state_t     state;
   logic [3:0] cnt;
   logic       hit;
   logic       drop;
   logic       ovf;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Reference model: window open flag, total matches in the window (unbounded),
   // hit cycles still to come.
   bit m_win   = 1'b0;
   int m_count = 0;
   int m_hits  = 0;

   // Observations taken after inputs settle, before the clock edge.
   logic   pre_hit;
   logic   pre_drop;
   logic   pre_busy;
   state_t pre_state;

   always #5 clock = ~clock;

   match_burst_fsm #(
      .SYM_W (4),
      .CNT_W (4)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .valid   (valid),
      .num     (num),
      .seq     (seq),
      .mask    (mask),
      .state   (state),
      .cnt     (cnt),
      .hit     (hit),
      .drop    (drop),
      .ovf     (ovf),
      .busy    (busy)
   );

   function automatic bit is_match(logic [3:0] s, logic [3:0] n, logic [3:0] m);
      return ((s ^ n) & m) == 4'd0;
   endfunction

   function automatic state_t exp_state();
      if (m_hits > 0) return ASSERT;
      if (m_win)      return WATCH;
      return WAIT;
   endfunction

   function automatic logic [3:0] exp_cnt();
      if (m_hits > 0) return 4'(m_hits);
      if (m_win)      return 4'((m_count > MAXC) ? MAXC : m_count);
      return 4'd0;
   endfunction

   function automatic logic exp_ovf();
      return m_count > MAXC;
   endfunction

   task automatic model_step(input logic v, input logic [3:0] s, input logic r);
      if (!r) begin
         m_win = 1'b0; m_count = 0; m_hits = 0;
      end else if (m_hits > 0) begin
         m_hits = m_hits - 1;
      end else if (m_win) begin
         if (v) begin
            m_count = m_count + int'(is_match(s, num, mask));
         end else begin
            m_win  = 1'b0;
            m_hits = (m_count > MAXC) ? MAXC : m_count;
         end
      end else if (v) begin
         m_win   = 1'b1;
         m_count = int'(is_match(s, num, mask));
      end
   endtask

   // Apply inputs for one cycle, advance the model at the edge.
   task automatic drive(input logic v, input logic [3:0] s, input logic r);
      @(negedge clock);
      valid = v; seq = s; reset_n = r;
      #1;
      pre_hit = hit; pre_drop = drop; pre_busy = busy; pre_state = state;
      @(posedge clock);
      model_step(v, s, r);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (!m_win && m_hits == 0) break;
         drive(1'b0, 4'd0, 1'b1);
      end
   endtask

   task automatic test_reset();
      drive(1'b1, 4'd5, 1'b0);
      drive(1'b1, 4'd5, 1'b0);
      checks++; if (state !== WAIT) begin errors++; $display("FAIL reset_state got %0d want %0d", state, WAIT); end
      checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
      checks++; if ({hit, busy, drop} !== 3'b000) begin errors++; $display("FAIL reset_outs hit/busy/drop got %b want 000", {hit, busy, drop}); end
   endtask

   task automatic test_basic();
      logic [3:0] pat [4];
      int hits;
      pat[0] = 4'd5; pat[1] = 4'd3; pat[2] = 4'd5; pat[3] = 4'd5;
      num = 4'd5; mask = 4'hF;
      for (int i = 0; i < 4; i++) drive(1'b1, pat[i], 1'b1);
      checks++; if (cnt !== 4'd3 || state !== WATCH) begin errors++; $display("FAIL basic_count got cnt=%0d state=%0d want cnt=3 state=%0d", cnt, state, WATCH); end
      hits = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 4'd0, 1'b1);
         if (hit) hits++;
      end
      checks++; if (hits != 3) begin errors++; $display("FAIL basic_hits got %0d want 3", hits); end
      checks++; if (state !== WAIT || cnt !== 4'd0) begin errors++; $display("FAIL basic_end got state=%0d cnt=%0d want state=%0d cnt=0", state, cnt, WAIT); end
   endtask

   task automatic test_no_match();
      int hits;
      num = 4'd5; mask = 4'hF;
      drive(1'b1, 4'd0, 1'b1);
      drive(1'b1, 4'd9, 1'b1);
      checks++; if (state !== WATCH || cnt !== 4'd0) begin errors++; $display("FAIL nomatch_watch got state=%0d cnt=%0d want state=%0d cnt=0", state, cnt, WATCH); end
      hits = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 4'd0, 1'b1);
         if (hit) hits++;
      end
      checks++; if (hits != 0 || state !== WAIT || cnt !== 4'd0) begin errors++; $display("FAIL nomatch_end got hits=%0d state=%0d cnt=%0d want 0/%0d/0", hits, state, cnt, WAIT); end
   endtask

   task automatic test_saturate();
      int hits;
      mask = 4'h0;
      for (int i = 0; i < 20; i++) drive(1'b1, 4'($urandom), 1'b1);
      checks++; if (cnt !== 4'd15 || ovf !== 1'b1) begin errors++; $display("FAIL sat_count got cnt=%0d ovf=%b want cnt=15 ovf=1", cnt, ovf); end
      hits = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 4'd0, 1'b1);
         if (hit) hits++;
      end
      checks++; if (hits != 15) begin errors++; $display("FAIL sat_hits got %0d want 15", hits); end
      checks++; if (ovf !== 1'b1 || state !== WAIT) begin errors++; $display("FAIL sat_ovf_hold got ovf=%b state=%0d want ovf=1 state=%0d", ovf, state, WAIT); end
      drive(1'b1, 4'd0, 1'b1);
      checks++; if (ovf !== 1'b0 || state !== WATCH) begin errors++; $display("FAIL sat_ovf_clear got ovf=%b state=%0d want ovf=0 state=%0d", ovf, state, WATCH); end
      drain();
      mask = 4'hF;
   endtask

   task automatic test_mask();
      int hits;
      mask = 4'hC; num = 4'd4;
      for (int i = 0; i < 3; i++) drive(1'b1, 4'd7, 1'b1);
      checks++; if (cnt !== 4'd3) begin errors++; $display("FAIL mask_count got %0d want 3", cnt); end
      hits = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 4'd0, 1'b1);
         if (hit) hits++;
      end
      checks++; if (hits != 3) begin errors++; $display("FAIL mask_hits got %0d want 3", hits); end
      mask = 4'hF; num = 4'd5;
   endtask

   task automatic test_drop();
      int hits;
      num = 4'd5; mask = 4'hF;
      for (int i = 0; i < 3; i++) drive(1'b1, 4'd5, 1'b1);
      drive(1'b0, 4'd0, 1'b1);
      hits = hit ? 1 : 0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 4'd5, 1'b1);
         checks++; if (pre_drop !== 1'b1 || pre_state !== ASSERT) begin errors++; $display("FAIL drop_flag k=%0d got drop=%b state=%0d want drop=1 state=%0d", k, pre_drop, pre_state, ASSERT); end
         if (hit) hits++;
      end
      drive(1'b1, 4'd5, 1'b1);
      checks++; if (pre_drop !== 1'b0 || pre_state !== WAIT) begin errors++; $display("FAIL drop_wait got drop=%b state=%0d want drop=0 state=%0d", pre_drop, pre_state, WAIT); end
      checks++; if (hits != 3) begin errors++; $display("FAIL drop_hits got %0d want 3", hits); end
      checks++; if (state !== WATCH || cnt !== 4'd1) begin errors++; $display("FAIL drop_rewatch got state=%0d cnt=%0d want state=%0d cnt=1", state, cnt, WATCH); end
      drain();
   endtask

   task automatic test_reset_mid();
      int hits;
      num = 4'd5; mask = 4'hF;
      for (int i = 0; i < 3; i++) drive(1'b1, 4'd5, 1'b1);
      drive(1'b0, 4'd0, 1'b1);
      drive(1'b0, 4'd0, 1'b0);
      checks++; if (pre_hit !== 1'b1) begin errors++; $display("FAIL rstmid_prehit got %b want 1", pre_hit); end
      checks++; if (state !== WAIT || cnt !== 4'd0 || hit !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rstmid_after got state=%0d cnt=%0d hit=%b ovf=%b want %0d/0/0/0", state, cnt, hit, ovf, WAIT); end
      hits = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 4'd0, 1'b1);
         if (hit) hits++;
      end
      checks++; if (hits != 0) begin errors++; $display("FAIL rstmid_nohits got %0d want 0", hits); end
   endtask

   task automatic test_random();
      logic       v, r, e_drop, e_hit, e_busy;
      logic [3:0] s;
      for (int i = 0; i < 600; i++) begin
         if (!m_win && m_hits == 0 && $urandom_range(0, 3) == 0) begin
            num  = 4'($urandom);
            mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
         end
         v = ($urandom_range(0, 2) != 0);
         r = ($urandom_range(0, 80) != 0);
         s = ($urandom_range(0, 1) == 0) ? num : 4'($urandom);
         e_hit  = (m_hits > 0);
         e_drop = v && (m_hits > 0);
         e_busy = (m_hits > 0) || m_win;
         drive(v, s, r);
         checks++; if ({pre_hit, pre_drop, pre_busy} !== {e_hit, e_drop, e_busy}) begin errors++; $display("FAIL rand_comb cyc=%0d hit/drop/busy got %b want %b", i, {pre_hit, pre_drop, pre_busy}, {e_hit, e_drop, e_busy}); end
         checks++; if (state !== exp_state()) begin errors++; $display("FAIL rand_state cyc=%0d got %0d want %0d", i, state, exp_state()); end
         checks++; if (cnt !== exp_cnt()) begin errors++; $display("FAIL rand_cnt cyc=%0d got %0d want %0d", i, cnt, exp_cnt()); end
         checks++; if (ovf !== exp_ovf()) begin errors++; $display("FAIL rand_ovf cyc=%0d got %b want %b", i, ovf, exp_ovf()); end
      end
      drain();
   endtask

   initial begin
      reset_n = 1'b0; valid = 1'b0; seq = 4'd0; num = 4'd5; mask = 4'hF;
      test_reset();
      test_basic();
      test_no_match();
      test_saturate();
      test_mask();
      test_drop();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
